// File: rtl/pll_reset_sequencer_if.sv
// Signal bundle between the PLL reset sequencer and the PLL / system reset tree.
// The master modport is the sequencer side; the slave modport is the PLL/system side.
interface pll_reset_sequencer_if;
  logic       pll_locked;
  logic       pll_rst;
  logic       sys_rst;
  logic [2:0] state;
  logic [7:0] lock_lost_cnt;

  modport master (
    input  pll_locked,
    output pll_rst,
    output sys_rst,
    output state,
    output lock_lost_cnt
  );

  modport slave (
    output pll_locked,
    input  pll_rst,
    input  sys_rst,
    input  state,
    input  lock_lost_cnt
  );
endinterface

// File: rtl/pll_reset_sequencer.sv
// Filters the raw PLL lock into a system reset that releases only after stable lock.
// Define PLL_LOCK_TIMEOUT_EN to pulse pll_rst when lock does not arrive in time.
module pll_reset_sequencer #(
  parameter int unsigned LOCK_STABLE_CYCLES = 1024,
  parameter int unsigned RESET_HOLD_CYCLES  = 16,
  parameter int unsigned LOSS_FILTER_CYCLES = 4,
  parameter int unsigned TIMEOUT_CYCLES     = 250000,
  parameter int unsigned PLL_RST_CYCLES     = 32
) (
  input logic                   clk,
  input logic                   rst,
  pll_reset_sequencer_if.master io
);

  typedef enum logic [2:0] {
    WAIT_LOCK = 3'd0,
    STABLE    = 3'd1,
    HOLD      = 3'd2,
    RUN       = 3'd3,
    PLL_RST   = 3'd4
  } state_t;

  localparam int unsigned MAX_A = (LOCK_STABLE_CYCLES > RESET_HOLD_CYCLES) ?
                                  LOCK_STABLE_CYCLES : RESET_HOLD_CYCLES;
  localparam int unsigned MAX_B = (MAX_A > LOSS_FILTER_CYCLES) ? MAX_A : LOSS_FILTER_CYCLES;
`ifdef PLL_LOCK_TIMEOUT_EN
  localparam int unsigned MAX_C = (MAX_B > TIMEOUT_CYCLES) ? MAX_B : TIMEOUT_CYCLES;
  localparam int unsigned MAX_P = (MAX_C > PLL_RST_CYCLES) ? MAX_C : PLL_RST_CYCLES;
`else
  localparam int unsigned MAX_P = MAX_B;
`endif
  localparam int unsigned CW = $clog2(MAX_P) + 1;

  if (LOCK_STABLE_CYCLES < 1 || RESET_HOLD_CYCLES < 1 || LOSS_FILTER_CYCLES < 1 ||
      TIMEOUT_CYCLES < 1 || PLL_RST_CYCLES < 1) begin : g_param_check
    $error("pll_reset_sequencer: all cycle parameters must be >= 1");
  end

  logic [1:0]    sync_q;
  logic          locked_s;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sys_rst_q, sys_rst_d;
  logic [7:0]    lost_q, lost_d;

  assign locked_s = sync_q[1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    lost_d  = lost_q;
    case (state_q)
      WAIT_LOCK: begin
        if (locked_s) state_d = STABLE;
`ifdef PLL_LOCK_TIMEOUT_EN
        else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) state_d = PLL_RST;
`else
        else cnt_d = cnt_q;
`endif
      end
      STABLE: begin
        if (!locked_s) state_d = WAIT_LOCK;
        else if (cnt_q == CW'(LOCK_STABLE_CYCLES - 1)) state_d = HOLD;
      end
      HOLD: begin
        if (!locked_s) state_d = WAIT_LOCK;
        else if (cnt_q == CW'(RESET_HOLD_CYCLES - 1)) state_d = RUN;
      end
      RUN: begin
        // In RUN the shared counter measures the current run of unlocked cycles.
        if (locked_s) begin
          cnt_d = '0;
        end else if (cnt_q == CW'(LOSS_FILTER_CYCLES - 1)) begin
          state_d = WAIT_LOCK;
          if (lost_q != '1) lost_d = lost_q + 8'd1;
        end
      end
      PLL_RST: begin
`ifdef PLL_LOCK_TIMEOUT_EN
        if (cnt_q == CW'(PLL_RST_CYCLES - 1)) state_d = WAIT_LOCK;
`else
        state_d = WAIT_LOCK;
`endif
      end
      default: state_d = WAIT_LOCK;
    endcase
    if (state_d != state_q) cnt_d = '0;
    sys_rst_d = (state_d != RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q    <= '0;
      state_q   <= WAIT_LOCK;
      cnt_q     <= '0;
      sys_rst_q <= 1'b1;
      lost_q    <= '0;
    end else begin
      sync_q    <= {sync_q[0], io.pll_locked};
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sys_rst_q <= sys_rst_d;
      lost_q    <= lost_d;
    end
  end

`ifdef PLL_LOCK_TIMEOUT_EN
  logic pll_rst_q, pll_rst_d;
  assign pll_rst_d = (state_d == PLL_RST);
  always_ff @(posedge clk) begin
    if (rst) pll_rst_q <= 1'b0;
    else     pll_rst_q <= pll_rst_d;
  end
  assign io.pll_rst = pll_rst_q;
`else
  assign io.pll_rst = 1'b0;
`endif

  assign io.sys_rst       = sys_rst_q;
  assign io.state         = state_q;
  assign io.lock_lost_cnt = lost_q;

endmodule
